instr_mem_responder: RTL

//  Instruction-side responder to program_counter: takes the byte address the PC drives each cycle and returns the addressed
//  32-bit instruction word one cycle later, with a valid flag for decode.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/byte_word_assembler.sv | 37 +++
 rtl/instr_mem_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: default instruction, PC control codes and
// the responder's state encoding.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  PC_HALT   = 7'h7F;
  localparam logic [6:0]  PC_JUMP   = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } imr_state_e;

endpackage

// File: rtl/byte_word_assembler.sv
// Collects little-endian bytes into a 32-bit word; word_done pulses
// combinationally alongside the 4th byte so the word can be written that edge.
module byte_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] lanes;
  logic [1:0]  byte_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lanes    <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
    end else if (byte_valid) begin
      case (byte_cnt)
        2'd0:    lanes[7:0]   <= byte_in;
        2'd1:    lanes[15:8]  <= byte_in;
        2'd2:    lanes[23:16] <= byte_in;
        default: lanes        <= lanes;
      endcase
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // The top lane bypasses the register so the full word is ready on the 4th byte.
  assign word      = {byte_in, lanes};
  assign word_done = byte_valid && !clr && (byte_cnt == 2'd3);

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction RAM responder for program_counter: byte-serial load mode,
// then registered one-cycle fetch honouring the PC halt/jump codes.
module instr_mem_responder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ins_add,
  input  logic [6:0]       pc_scr,
  input  logic             load_en,
  input  logic             load_valid,
  input  logic [7:0]       load_byte,
  output logic [31:0]      instruction,
  output logic             ins_valid,
  output logic [IDX_W-1:0] load_ptr,
  output logic             addr_err
);

  import cpu_pkg::*;

  imr_state_e state, state_next;

  logic [31:0]      mem [DEPTH];
  logic [31:0]      asm_word;
  logic             word_done;
  logic             byte_valid;
  logic             asm_clr;
  logic             load_entry;
  logic             bad_addr;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    byte_valid = 1'b0;
    asm_clr    = 1'b1;
    case (state)
      ST_IDLE: state_next = load_en ? ST_LOAD : ST_RUN;
      ST_LOAD: begin
        if (!load_en) state_next = ST_RUN;
        byte_valid = load_en && load_valid;
        // Leaving LOAD drops any partially assembled word.
        asm_clr    = !load_en;
      end
      ST_RUN:  if (load_en) state_next = ST_LOAD;
      default: state_next = ST_IDLE;
    endcase
    load_entry = (state_next == ST_LOAD) && (state != ST_LOAD);
  end

  assign idx      = ins_add[IDX_W+1:2];
  assign bad_addr = (|ins_add[1:0]) || (|ins_add[WIDTH-1:IDX_W+2]);

  byte_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .byte_valid (byte_valid),
    .byte_in    (load_byte),
    .word       (asm_word),
    .word_done  (word_done)
  );

  always_ff @(posedge clk) begin
    if (word_done) mem[load_ptr] <= asm_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction <= NOP_INSTR;
      ins_valid   <= 1'b0;
      addr_err    <= 1'b0;
      load_ptr    <= '0;
    end else begin
      if (state != ST_RUN) begin
        instruction <= NOP_INSTR;
        ins_valid   <= 1'b0;
      end else if (pc_scr == PC_HALT) begin
        instruction <= instruction;
        ins_valid   <= ins_valid;
      end else if (pc_scr == PC_JUMP) begin
        instruction <= NOP_INSTR;
        ins_valid   <= 1'b0;
      end else if (bad_addr) begin
        instruction <= NOP_INSTR;
        ins_valid   <= 1'b0;
        addr_err    <= 1'b1;
      end else begin
        instruction <= mem[idx];
        ins_valid   <= 1'b1;
      end

      // Entry clear comes last so it wins over a same-edge error flag.
      if (load_entry) begin
        load_ptr <= '0;
        addr_err <= 1'b0;
      end else if (word_done) begin
        load_ptr <= load_ptr + IDX_W'(1);
      end
    end
  end

endmodule
